// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: round-robin, packet-locked arbiter sharing one wide AXI-Stream consumer among NUM_PORTS requesters
module axis_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  input  logic                            m_axis_tready,
  output logic                            grant_active,
  output logic [ID_WIDTH-1:0]             grant_idx
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0]          state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] pick;
  logic                hs;
  // round-robin search: scanning downward lets the port closest after last_grant win
  always_comb begin
    pick = last_grant;
    for (int k = NUM_PORTS; k >= 1; k--)
      if (s_axis_tvalid[(int'(last_grant) + k) % NUM_PORTS])
        pick = ID_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
  end
  // only the locked port sees ready, and only while the output slot can take a beat
  always_comb begin
    s_axis_tready = '0;
    if (state == LOCKED) s_axis_tready[grant_idx] = !m_axis_tvalid || m_axis_tready;
  end
  assign hs           = s_axis_tready[grant_idx] && s_axis_tvalid[grant_idx];
  assign grant_active = state == LOCKED;
  // arbitration, packet lock release on tlast, and the single-entry output stage
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      last_grant    <= ID_WIDTH'(NUM_PORTS - 1);
      grant_idx     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
    end else begin
      if (state == IDLE && |s_axis_tvalid) begin
        grant_idx <= pick;
        state     <= LOCKED;
      end
      if (hs) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast  <= s_axis_tlast[grant_idx];
        m_axis_tid    <= grant_idx;
        if (s_axis_tlast[grant_idx]) begin
          last_grant <= grant_idx;
          state      <= IDLE;
        end
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed and randomized bench against a cycle-level behavioural model
module tb_axis_packet_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int IW = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic            areset;
  logic [N*W-1:0]  s_tdata;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [W-1:0]    m_tdata;
  logic            m_tvalid, m_tlast, m_tready, grant_active;
  logic [IW-1:0]   m_tid, grant_idx;
  axis_packet_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(W)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tready(m_tready), .grant_active(grant_active), .grant_idx(grant_idx)
  );
  int checks = 0, failures = 0;
  bit mlock, mov, mol;
  int mlast, mgidx, moid;
  logic [63:0] mod;
  int hs_port = -1, in_hs = 0, obs_beats = 0;
  int glog[$];
  bit prev_ga = 1'b0;
  logic [64:0] pq[N][$];
  bit pause[N];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    mlock = 0; mov = 0; mol = 0; mlast = N - 1; mgidx = 0; moid = 0; mod = '0;
  endtask
  task automatic add_pkt(input int port, input int len, input logic [63:0] base);
    for (int b = 0; b < len; b++) pq[port].push_back({b == len - 1, base + 64'(b)});
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hs_port == i) void'(pq[i].pop_front());
      if (!(s_tvalid[i] && hs_port != i)) s_tvalid[i] = pq[i].size() > 0 && !pause[i];
      s_tdata[i*W +: W] = pq[i].size() > 0 ? pq[i][0][63:0] : '0;
      s_tlast[i] = pq[i].size() > 0 ? pq[i][0][64] : 1'b0;
    end
    hs_port = -1;
  endtask
  task automatic cycle();
    logic [N-1:0] er;
    int p;
    @(negedge clk);
    er = '0;
    if (mlock && (!mov || m_tready)) er[mgidx] = 1'b1;
    chk("s_tready", s_tready, er);
    chk("m_tvalid", m_tvalid, mov);
    chk("grant_active", grant_active, mlock);
    chk("grant_idx", grant_idx, mgidx);
    if (mov) begin
      chk("m_tdata", m_tdata, mod);
      chk("m_tlast", m_tlast, mol);
      chk("m_tid", m_tid, moid);
    end
    if (grant_active && !prev_ga) glog.push_back(int'(grant_idx));
    prev_ga = grant_active;
    if (m_tvalid && m_tready) obs_beats++;
    hs_port = -1;
    if (areset) model_reset();
    else begin
      if (mlock && er[mgidx] && s_tvalid[mgidx]) hs_port = mgidx;
      if (!mlock && s_tvalid != 0) begin
        for (int k = 1; k <= N; k++) begin
          p = (mlast + k) % N;
          if (s_tvalid[p]) begin
            mgidx = p;
            break;
          end
        end
        mlock = 1;
      end
      if (hs_port >= 0) begin
        in_hs++;
        mov = 1; mod = s_tdata[hs_port*W +: W]; mol = s_tlast[hs_port]; moid = hs_port;
        if (mol) begin
          mlast = hs_port;
          mlock = 0;
        end
      end else if (m_tready) mov = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      drive();
      cycle();
    end
  endtask
  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      pause[i] = 0;
    end
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; hs_port = -1;
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    glog.delete();
    obs_beats = 0;
    in_hs = 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, m_tvalid, 0);
    chk({tag, "_m_tdata"}, m_tdata, 0);
    chk({tag, "_m_tlast"}, m_tlast, 0);
    chk({tag, "_m_tid"}, m_tid, 0);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_grant_active"}, grant_active, 0);
    chk({tag, "_grant_idx"}, grant_idx, 0);
  endtask
  initial begin
    int pat[4] = '{1, 0, 0, 1};
    areset = 1'b1; m_tready = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    for (int i = 0; i < N; i++) pause[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    areset = 1'b0;
    chk_reset_outputs("init");
    // single requester: port 2 sends A,B,C
    reset_dut();
    m_tready = 1'b1;
    add_pkt(2, 3, 64'hA0);
    run(1);
    chk("t1_grant_idx", grant_idx, 2);
    chk("t1_s_tready", s_tready, 4'b0100);
    chk("t1_no_beat_yet", m_tvalid, 0);
    run(1);
    chk("t1_beat_a", m_tdata, 64'hA0);
    chk("t1_tid_a", m_tid, 2);
    chk("t1_tlast_a", m_tlast, 0);
    run(2);
    chk("t1_beat_c", m_tdata, 64'hA2);
    chk("t1_tlast_c", m_tlast, 1);
    chk("t1_back_idle", grant_active, 0);
    run(1);
    chk("t1_drained", m_tvalid, 0);
    chk("t1_grant_kept", grant_idx, 2);
    // all four ports, two 2-beat packets each
    reset_dut();
    m_tready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) add_pkt(i, 2, 64'h100 * (r * N + i + 1));
    run(30);
    chk("t2_grant_count", glog.size(), 8);
    for (int j = 0; j < 8; j++)
      if (j < glog.size()) chk("t2_grant_order", glog[j], j % N);
    chk("t2_beats", obs_beats, 16);
    // backpressure on a 4-beat packet from port 1
    reset_dut();
    m_tready = 1'b1;
    add_pkt(1, 4, 64'hB0);
    run(2);
    for (int j = 0; j < 4; j++) begin
      m_tready = pat[j][0];
      run(1);
    end
    m_tready = 1'b1;
    run(8);
    chk("t3_beats", obs_beats, 4);
    // gap mid-packet on port 0 while port 3 waits
    reset_dut();
    add_pkt(0, 3, 64'hC0);
    add_pkt(3, 1, 64'hD0);
    run(2);
    pause[0] = 1;
    run(3);
    chk("t4_lock_held", grant_active, 1);
    chk("t4_lock_port", grant_idx, 0);
    pause[0] = 0;
    run(8);
    chk("t4_grant_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t4_first", glog[0], 0);
      chk("t4_second", glog[1], 3);
    end
    // reset mid-packet
    reset_dut();
    add_pkt(2, 5, 64'hE0);
    run(3);
    chk("t5_partial_beats", in_hs, 2);
    reset_dut();
    chk_reset_outputs("t5");
    add_pkt(2, 1, 64'hF2);
    add_pkt(0, 1, 64'hF0);
    run(6);
    chk("t5_grant_count", glog.size(), 2);
    if (glog.size() > 0) chk("t5_first_after_reset", glog[0], 0);
    // back-to-back packets from port 3
    reset_dut();
    add_pkt(3, 2, 64'h300);
    add_pkt(3, 2, 64'h310);
    run(10);
    chk("t6_grant_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t6_first", glog[0], 3);
      chk("t6_second", glog[1], 3);
    end
    chk("t6_beats", obs_beats, 4);
    // randomized traffic, backpressure, gaps and occasional resets
    reset_dut();
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) reset_dut();
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(0, 3) == 0)
          add_pkt(i, int'($urandom_range(1, 4)), {$urandom, $urandom});
        pause[i] = $urandom_range(0, 3) == 0;
      end
      m_tready = $urandom_range(0, 3) != 0;
      drive();
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
